shift_exec_unit: RTL and testbench
==================================

// Module: shift_exec_unit
//
// PURPOSE
// - Pipelined execute-stage shift unit. Takes shift requests (SLL/SRL/SRA) from the issue
//   stage over a valid/ready handshake and returns tagged results to writeback.
// - Performs all three shifts on the team's single left logical barrel shifter:
//   bit-reverse on the way in, bit-reverse back on the way out, sign fill for SRA.
// - 2-stage pipeline, one request per cycle, full backpressure and flush support.
//
// PARAMETERS
// - WIDTH  32  operand/result width; only 32 is legal (elaboration-time assertion).
// - TAG_W   5  width of the opaque destination tag carried with each request.
//
// PORTS
// - clk          in   1       clock; all state updates on rising edge
// - rst_n        in   1       asynchronous, active-low reset
// - flush        in   1       synchronous pipeline flush (branch mispredict/trap)
// - in_valid     in   1       request valid
// - in_ready     out  1       unit can accept a request this cycle
// - in_op        in   2       shift_op_e: 00 SLL, 01 SRL, 10 SRA, 11 illegal
// - in_a         in   WIDTH   operand to shift
// - in_shamt     in   5       shift amount, 0..31
// - in_tag       in   TAG_W   destination tag, passed through unchanged
// - out_valid    out  1       result valid
// - out_ready    in   1       consumer accepts the result
// - out_data     out  WIDTH   shift result
// - out_tag      out  TAG_W   tag of the result
// - out_illegal  out  1       request carried op 2'b11
//
// BEHAVIOUR
// - Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_data=0, out_tag=0, out_illegal=0.
//   All stage payload registers are cleared. in_ready is 1 (both stages empty).
// - Stage S1 captures {op,a,shamt,tag} on in_valid&&in_ready.
//   S2 is the output register and drives out_*.
// - Advance rules:
//   - s2_free  = !out_valid || out_ready
//   - s1_adv   = s1_valid && s2_free
//   - in_ready = (!s1_valid || s2_free) && !flush
// - Latency: a request accepted at edge N is presented with out_valid=1 after edge N+1.
//   Throughput is 1/cycle when out_ready stays high.
// - Output stability: while out_valid && !out_ready, out_data, out_tag and out_illegal hold.
//   Order is always preserved and no request is lost or duplicated.
// - S1->S2 datapath (combinational, from S1 registers):
//   - SLL: y = shl(a, shamt)
//   - SRL: y = rev(shl(rev(a), shamt))
//   - SRA: the SRL result OR'd with the top shamt bits of the fill mask
//     mask = rev(shl(all_ones, shamt)), inverted, applied only when a[31]=1
//   - illegal (2'b11): y = a, out_illegal = 1
//   - shamt = 0 returns a unchanged for every op
// - flush=1 at an edge: s1_valid and out_valid become 0 and in-flight items are dropped.
//   No request is accepted that cycle. flush has priority over the handshake;
//   payload registers may keep stale data.
// - A mid-stream reset discards everything. No out_valid is produced for pre-reset
//   requests after rst_n deasserts.
// - out_* are registered; there is no combinational path from in_* to out_*.
// - in_ready depends combinationally on out_ready and flush only.
//
// STRUCTURE
// - shift_pkg: typedef enum logic [1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_ILL};
//   localparam SHAMT_W = 5; function bit_reverse32().
// - Instantiate the existing left logical barrel shifter twice:
//   - once for the data path
//   - once for the SRA fill mask (input all-ones)
// - No other sub-modules; pipeline control is in this file.
//
// TESTING
// - SLL a=32'h0000_0001 shamt=31 tag=3 -> out_data=32'h8000_0000, out_tag=3,
//   out_valid 2 edges after accept.
// - a=32'h8000_0000 shamt=4: SRA -> 32'hF800_0000, SRL -> 32'h0800_0000.
//   SRA a=32'h7FFF_FFFF shamt=31 -> 32'h0.
// - shamt=0, a=32'hDEAD_BEEF for SLL/SRL/SRA -> 32'hDEAD_BEEF.
//   op=2'b11 -> out_data=a, out_illegal=1.
// - 4 back-to-back requests with out_ready=0 for 3 cycles
//   -> in_ready drops after 2 accepts, outputs hold stable, all 4 delivered in order.
// - Both stages full, flush pulsed for 1 cycle -> out_valid=0 next cycle,
//   dropped tags never appear, next request after flush completes normally.
// - rst_n pulsed low mid-stream -> out_valid=0 immediately (async), all outputs 0,
//   no stale results after release.

Source files
------------

// File: rtl/shift_exec_unit_pkg.sv
// Shared types and helpers for the execute-stage shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ILL = 2'b11
  } shift_op_e;

  localparam int SHAMT_W = 5;

  // Mirror bit order so right shifts can reuse the left shifter.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_exec_unit_shl.sv
// Left logical barrel shifter: one mux stage per shift-amount bit.
module shift_exec_unit_shl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   y
);

  logic [SHAMT_W:0][WIDTH-1:0] stg;

  assign stg[0] = a;

  // Stage i shifts by 2**i when shamt bit i is set.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stg
    assign stg[i+1] = shamt[i] ? (stg[i] << (2**i)) : stg[i];
  end

  assign y = stg[SHAMT_W];

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage execute shift unit (SLL/SRL/SRA) with valid/ready, flush and tag passthrough.
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [4:0]         in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal
);

  if (WIDTH != 32) begin : g_bad_width
    $error("shift_exec_unit: WIDTH must be 32");
  end

  // S1 registers
  logic               s1_valid;
  shift_op_e          s1_op;
  logic [WIDTH-1:0]   s1_a;
  logic [SHAMT_W-1:0] s1_shamt;
  logic [TAG_W-1:0]   s1_tag;

  logic s2_free, s1_adv, accept;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = (!s1_valid || s2_free) && !flush;
  assign accept   = in_valid && in_ready;

  // S1 capture; flush wins over the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= SH_SLL;
      s1_a     <= '0;
      s1_shamt <= '0;
      s1_tag   <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (accept) begin
        s1_op    <= shift_op_e'(in_op);
        s1_a     <= in_a;
        s1_shamt <= in_shamt;
        s1_tag   <= in_tag;
      end
    end
  end

  // Right shifts run through the left shifter on bit-reversed data.
  logic [WIDTH-1:0] dp_in, dp_out, mask_out, srl_y, sra_fill, y;

  assign dp_in = (s1_op == SH_SLL) ? s1_a : bit_reverse32(s1_a);

  shift_exec_unit_shl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_dp (
    .a(dp_in), .shamt(s1_shamt), .y(dp_out)
  );

  // Fill mask: top shamt bits set, used to sign-extend SRA.
  shift_exec_unit_shl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_mask (
    .a({WIDTH{1'b1}}), .shamt(s1_shamt), .y(mask_out)
  );

  assign srl_y    = bit_reverse32(dp_out);
  assign sra_fill = ~bit_reverse32(mask_out);

  // Result select per op.
  always_comb begin
    y = s1_a;
    case (s1_op)
      SH_SLL:  y = dp_out;
      SH_SRL:  y = srl_y;
      SH_SRA:  y = s1_a[WIDTH-1] ? (srl_y | sra_fill) : srl_y;
      default: y = s1_a;
    endcase
  end

  // S2 output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (flush)        out_valid <= 1'b0;
      else if (s2_free) out_valid <= s1_valid;
      if (s1_adv) begin
        out_data    <= y;
        out_tag     <= s1_tag;
        out_illegal <= (s1_op == SH_ILL);
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed plus randomized bench for shift_exec_unit with a queue-based reference model.
module tb_shift_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_illegal;

  shift_exec_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic acc;

  // Reference shift, straight from the arithmetic definition of each op.
  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] a, logic [4:0] sh);
    case (op)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return $unsigned($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, then update the model.
  task automatic tick();
    logic del, fl;
    exp_t got, e;
    #1;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    fl  = flush;
    got = '{data: out_data, tag: out_tag, ill: out_illegal};
    e   = '{data: ref_shift(in_op, in_a, in_shamt), tag: in_tag, ill: (in_op == 2'b11)};
    @(posedge clk);
    #1;
    if (del) begin
      chk("no_stray_output", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("out_data", got.data, x.data);
        chk("out_tag", 32'(got.tag), 32'(x.tag));
        chk("out_illegal", 32'(got.ill), 32'(x.ill));
      end
    end
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(e);
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [31:0] a, logic [4:0] sh, logic [4:0] tg);
    in_valid = v; in_op = op; in_a = a; in_shamt = sh; in_tag = tg;
  endtask

  // Single request through an empty pipe, checked against a known constant.
  task automatic single(string nm, logic [1:0] op, logic [31:0] a, logic [4:0] sh,
                        logic [4:0] tg, logic [31:0] exp, logic ill);
    out_ready = 1'b1;
    drive(1'b1, op, a, sh, tg);
    tick();
    in_valid = 1'b0;
    chk({nm, "_lat_n1"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tg));
    chk({nm, "_ill"}, 32'(out_illegal), 32'(ill));
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] held_d;
  logic [4:0]  held_t;
  int          sent;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_ill", 32'(out_illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed shifts
    single("sll31", 2'b00, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000, 1'b0);
    single("sra4",  2'b10, 32'h8000_0000, 5'd4,  5'd4, 32'hF800_0000, 1'b0);
    single("srl4",  2'b01, 32'h8000_0000, 5'd4,  5'd5, 32'h0800_0000, 1'b0);
    single("sra31", 2'b10, 32'h7FFF_FFFF, 5'd31, 5'd6, 32'h0000_0000, 1'b0);
    single("sll0",  2'b00, 32'hDEAD_BEEF, 5'd0,  5'd7, 32'hDEAD_BEEF, 1'b0);
    single("srl0",  2'b01, 32'hDEAD_BEEF, 5'd0,  5'd8, 32'hDEAD_BEEF, 1'b0);
    single("sra0",  2'b10, 32'hDEAD_BEEF, 5'd0,  5'd9, 32'hDEAD_BEEF, 1'b0);
    single("ill",   2'b11, 32'h1234_5678, 5'd7,  5'd10, 32'h1234_5678, 1'b1);
    single("sra31n", 2'b10, 32'h8000_0001, 5'd31, 5'd11, 32'hFFFF_FFFF, 1'b0);

    // Backpressure: two accepts fill the pipe, then in_ready drops and outputs hold
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_00F0, 5'd4, 5'd20); tick();
    drive(1'b1, 2'b01, 32'hF000_0000, 5'd8, 5'd21); tick();
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    held_d = out_data; held_t = out_tag;
    drive(1'b1, 2'b10, 32'h8000_00FF, 5'd12, 5'd22); tick();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", out_data, held_d);
    chk("bp_hold_tag", 32'(out_tag), 32'(held_t));
    chk("bp_hold_data_val", out_data, 32'h0000_0F00);
    out_ready = 1'b1;
    sent = 2;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      if (sent == 2) drive(1'b1, 2'b10, 32'h8000_00FF, 5'd12, 5'd22);
      else           drive(1'b1, 2'b11, 32'hCAFE_F00D, 5'd3, 5'd23);
      tick();
      if (acc) sent++;
    end
    chk("bp_all_sent", 32'(sent), 32'd4);
    drain();

    // Flush with both stages full
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h1, 5'd1, 5'd30); tick();
    drive(1'b1, 2'b00, 32'h1, 5'd2, 5'd31); tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_no_resurrect", 32'(out_valid), 32'd0);
    single("post_flush", 2'b01, 32'hFFFF_0000, 5'd16, 5'd12, 32'h0000_FFFF, 1'b0);

    // Async reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'hA5A5_A5A5, 5'd1, 5'd13); tick();
    drive(1'b1, 2'b01, 32'hA5A5_A5A5, 5'd1, 5'd14); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    chk("arst_out_ill", 32'(out_illegal), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random stalls and occasional flush
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      tick();
    end
    flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
